// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the EX-stage branch resolve unit: compare codes
// produced by the ID decoder and the flush FSM states.
package branch_resolve_unit_pkg;

  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_EQ   = 3'd1;
  localparam logic [2:0] CMP_NE   = 3'd2;
  localparam logic [2:0] CMP_LT   = 3'd3;
  localparam logic [2:0] CMP_GE   = 3'd4;
  localparam logic [2:0] CMP_LTU  = 3'd5;
  localparam logic [2:0] CMP_GEU  = 3'd6;

  typedef enum logic [0:0] {
    BRU_IDLE  = 1'b0,
    BRU_FLUSH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Purely combinational branch comparator; reusable by an ID-stage early resolver.
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      cmp_ctrl,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  // Compare decode; unknown nonzero codes resolve to not taken
  always_comb begin
    taken = 1'b0;
    case (cmp_ctrl)
      CMP_EQ:  taken = (rs1 == rs2);
      CMP_NE:  taken = (rs1 != rs2);
      CMP_LT:  taken = ($signed(rs1) <  $signed(rs2));
      CMP_GE:  taken = ($signed(rs1) >= $signed(rs2));
      CMP_LTU: taken = (rs1 <  rs2);
      CMP_GEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: registered redirect pulse, wrong-path flush FSM
// and saturating branch statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             valid_ex,
  input  logic [2:0]       cmp_ctrl,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [XLEN-1:0]  pc_ex,
  input  logic [XLEN-1:0]  imm_ex,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             target_misaligned,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bru_state_e       state_r;
  logic [2:0]       flush_cnt_r;
  logic             redirect_valid_r;
  logic [XLEN-1:0]  redirect_pc_r;
  logic             target_misaligned_r;
  logic             flush_r;
  logic [CNT_W-1:0] br_count_r;
  logic [CNT_W-1:0] taken_count_r;

  logic             cmp_taken_s;
  logic             eval_s;
  logic             take_s;
  logic             count_br_s;
  logic [XLEN-1:0]  jalr_sum_s;
  logic [XLEN-1:0]  target_s;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .cmp_ctrl (cmp_ctrl),
    .rs1      (rs1_data),
    .rs2      (rs2_data),
    .taken    (cmp_taken_s)
  );

  assign eval_s     = valid_ex & ~stall & (state_r == BRU_IDLE);
  assign jalr_sum_s = rs1_data + imm_ex;
  // Jumps outrank the compare code so a confused decoder never double-counts
  assign count_br_s = eval_s & ~is_jalr & ~is_jal & (cmp_ctrl != CMP_NONE);

  // Target selection and take decision with JALR > JAL > compare priority
  always_comb begin
    target_s = pc_ex + imm_ex;
    take_s   = 1'b0;
    if (is_jalr) begin
      target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
      take_s   = 1'b1;
    end else if (is_jal) begin
      take_s   = 1'b1;
    end else begin
      take_s   = cmp_taken_s;
    end
  end

  // Redirect pulse and flush FSM; the pulse self-clears even while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r             <= BRU_IDLE;
      flush_cnt_r         <= 3'd0;
      redirect_valid_r    <= 1'b0;
      redirect_pc_r       <= {XLEN{1'b0}};
      target_misaligned_r <= 1'b0;
      flush_r             <= 1'b0;
    end else begin
      redirect_valid_r    <= 1'b0;
      target_misaligned_r <= 1'b0;
      if (!stall) begin
        case (state_r)
          BRU_IDLE: begin
            if (eval_s && take_s) begin
              redirect_valid_r    <= 1'b1;
              redirect_pc_r       <= target_s;
              target_misaligned_r <= target_s[1];
              state_r             <= BRU_FLUSH;
              flush_cnt_r         <= 3'(FLUSH_CYCLES);
              flush_r             <= 1'b1;
            end else begin
              state_r <= BRU_IDLE;
              flush_r <= 1'b0;
            end
          end
          BRU_FLUSH: begin
            if (flush_cnt_r == 3'd1) begin
              state_r     <= BRU_IDLE;
              flush_cnt_r <= 3'd0;
              flush_r     <= 1'b0;
            end else begin
              flush_cnt_r <= flush_cnt_r - 3'd1;
              flush_r     <= 1'b1;
            end
          end
          default: begin
            state_r     <= BRU_IDLE;
            flush_cnt_r <= 3'd0;
            flush_r     <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  // Saturating statistics counters for conditional branches only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count_r    <= {CNT_W{1'b0}};
      taken_count_r <= {CNT_W{1'b0}};
    end else if (count_br_s) begin
      if (br_count_r != CNT_MAX) begin
        br_count_r <= br_count_r + CNT_W'(1);
      end else begin
        br_count_r <= br_count_r;
      end
      if (cmp_taken_s && (taken_count_r != CNT_MAX)) begin
        taken_count_r <= taken_count_r + CNT_W'(1);
      end else begin
        taken_count_r <= taken_count_r;
      end
    end else begin
      br_count_r    <= br_count_r;
      taken_count_r <= taken_count_r;
    end
  end

  assign redirect_valid    = redirect_valid_r;
  assign redirect_pc       = redirect_pc_r;
  assign target_misaligned = target_misaligned_r;
  assign flush_if_id       = flush_r;
  assign flush_id_ex       = flush_r;
  assign br_count          = br_count_r;
  assign taken_count       = taken_count_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus hand-written
// wrong-path, stall, saturation and reset sequences (counters built 4 bits wide).
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, stall, valid_ex, is_jal, is_jalr;
  logic [2:0]       cmp_ctrl;
  logic [XLEN-1:0]  pc_ex, imm_ex, rs1_data, rs2_data;
  logic             redirect_valid, target_misaligned, flush_if_id, flush_id_ex;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_count, taken_count;

  int checks_total  = 0;
  int checks_passed = 0;
  int br_m = 0;
  int tk_m = 0;
  logic [31:0] last_pc = 32'h0;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .valid_ex(valid_ex),
    .cmp_ctrl(cmp_ctrl), .is_jal(is_jal), .is_jalr(is_jalr),
    .pc_ex(pc_ex), .imm_ex(imm_ex), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .target_misaligned(target_misaligned), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmp;
    logic        jal;
    logic        jalr;
    logic [31:0] rs1, rs2, pc, imm;
    logic        exp_taken;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic j, input logic jr,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] p, input logic [31:0] im);
    valid_ex = 1'b1; cmp_ctrl = c; is_jal = j; is_jalr = jr;
    rs1_data = r1; rs2_data = r2; pc_ex = p; imm_ex = im;
  endtask

  task automatic idle_inputs();
    valid_ex = 1'b0; cmp_ctrl = CMP_NONE; is_jal = 1'b0; is_jalr = 1'b0;
  endtask

  task automatic count_model(input logic taken);
    if (br_m < 15) br_m++;
    if (taken && tk_m < 15) tk_m++;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_br_count"}, 32'(br_count), 32'(br_m));
    check({tag, "_taken_count"}, 32'(taken_count), 32'(tk_m));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_redirect_valid"}, 32'(redirect_valid), 32'h0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    check({tag, "_misaligned"}, 32'(target_misaligned), 32'h0);
    check({tag, "_flush_if_id"}, 32'(flush_if_id), 32'h0);
    check({tag, "_flush_id_ex"}, 32'(flush_id_ex), 32'h0);
    check({tag, "_br_count"}, 32'(br_count), 32'h0);
    check({tag, "_taken_count"}, 32'(taken_count), 32'h0);
  endtask

  initial begin
    int flush_cycles;
    vecs[0]  = '{CMP_LT,   1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0};
    vecs[1]  = '{CMP_LTU,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{CMP_NONE, 1'b0, 1'b1, 32'h1003, 32'h0, 32'h80, 32'h4, 1'b1, 32'h1006, 1'b1};
    vecs[3]  = '{CMP_NONE, 1'b1, 1'b0, 32'h0, 32'h0, 32'h200, 32'hFFFF_FFF0, 1'b1, 32'h1F0, 1'b0};
    vecs[4]  = '{CMP_EQ,   1'b0, 1'b0, 32'h5, 32'h5, 32'h300, 32'h8, 1'b1, 32'h308, 1'b0};
    vecs[5]  = '{CMP_NE,   1'b0, 1'b0, 32'h5, 32'h5, 32'h300, 32'h8, 1'b0, 32'h0, 1'b0};
    vecs[6]  = '{CMP_GE,   1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h400, 32'h2, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{CMP_GEU,  1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h400, 32'h2, 1'b1, 32'h402, 1'b1};
    vecs[8]  = '{3'd7,     1'b0, 1'b0, 32'h1, 32'h2, 32'h440, 32'h8, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{CMP_EQ,   1'b1, 1'b0, 32'h7, 32'h7, 32'h500, 32'h10, 1'b1, 32'h510, 1'b0};
    vecs[10] = '{CMP_NONE, 1'b1, 1'b1, 32'h2000, 32'h0, 32'h600, 32'h1, 1'b1, 32'h2000, 1'b0};
    vecs[11] = '{CMP_LT,   1'b0, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h700, 32'h8, 1'b0, 32'h0, 1'b0};
    vecs[12] = '{CMP_EQ,   1'b0, 1'b0, 32'h9, 32'h9, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4, 1'b0};

    rst_n = 1'b0; stall = 1'b0; idle_inputs();
    pc_ex = 32'h0; imm_ex = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table-driven single evaluations, each followed by the flush window if taken
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].cmp, vecs[i].jal, vecs[i].jalr, vecs[i].rs1, vecs[i].rs2,
            vecs[i].pc, vecs[i].imm);
      step();
      idle_inputs();
      if (vecs[i].cmp != CMP_NONE && !vecs[i].jal && !vecs[i].jalr)
        count_model(vecs[i].exp_taken);
      if (vecs[i].exp_taken) last_pc = vecs[i].exp_pc;
      check($sformatf("v%0d_redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].exp_taken));
      check($sformatf("v%0d_redirect_pc", i), redirect_pc, last_pc);
      check($sformatf("v%0d_misaligned", i), 32'(target_misaligned),
            32'(vecs[i].exp_taken & vecs[i].exp_mis));
      check($sformatf("v%0d_flush_if_id", i), 32'(flush_if_id), 32'(vecs[i].exp_taken));
      check_counts($sformatf("v%0d", i));
      if (vecs[i].exp_taken) begin
        step();
        check($sformatf("v%0d_pulse_end", i), 32'(redirect_valid), 32'h0);
        check($sformatf("v%0d_flush_id_ex", i), 32'(flush_id_ex), 32'h1);
        step();
        check($sformatf("v%0d_flush_done", i), 32'(flush_if_id), 32'h0);
      end
    end

    // valid_ex low: nothing evaluated or counted
    drive(CMP_EQ, 1'b0, 1'b0, 32'h1, 32'h1, 32'h900, 32'h4);
    valid_ex = 1'b0;
    step();
    check("novalid_redirect", 32'(redirect_valid), 32'h0);
    check_counts("novalid");

    // stall in IDLE blocks evaluation
    drive(CMP_EQ, 1'b0, 1'b0, 32'h1, 32'h1, 32'h900, 32'h4);
    stall = 1'b1;
    step();
    stall = 1'b0; idle_inputs();
    check("idlestall_redirect", 32'(redirect_valid), 32'h0);
    check_counts("idlestall");

    // Wrong-path slots during FLUSH, including a taken BNE, are ignored
    drive(CMP_EQ, 1'b0, 1'b0, 32'h3, 32'h3, 32'hA00, 32'h40);
    step();
    count_model(1'b1);
    check("wp_redirect", 32'(redirect_valid), 32'h1);
    check("wp_pc", redirect_pc, 32'hA40);
    drive(CMP_NE, 1'b0, 1'b0, 32'h1, 32'h2, 32'hA04, 32'h80);
    step();
    check("wp_slot1_redirect", 32'(redirect_valid), 32'h0);
    check("wp_slot1_flush", 32'(flush_if_id), 32'h1);
    drive(CMP_NE, 1'b0, 1'b0, 32'h1, 32'h2, 32'hA08, 32'h80);
    step();
    idle_inputs();
    check("wp_slot2_redirect", 32'(redirect_valid), 32'h0);
    check("wp_back_idle", 32'(flush_if_id), 32'h0);
    check("wp_pc_held", redirect_pc, 32'hA40);
    check_counts("wp");

    // Stall during FLUSH stretches the flush but not the redirect pulse
    drive(CMP_GEU, 1'b0, 1'b0, 32'h9, 32'h2, 32'hB00, 32'h10);
    step();
    count_model(1'b1);
    check("st_redirect", 32'(redirect_valid), 32'h1);
    stall = 1'b1;
    flush_cycles = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (flush_if_id) flush_cycles++;
      if (k == 0) check("st_pulse_one_cycle", 32'(redirect_valid), 32'h0);
    end
    stall = 1'b0; idle_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      if (flush_if_id) flush_cycles++;
    end
    check("st_flush_len", 32'(flush_cycles), 32'd5);
    check_counts("st");

    // Saturation of both counters
    for (int k = 0; k < 20; k++) begin
      drive(CMP_NE, 1'b0, 1'b0, 32'h4, 32'h4, 32'hC00, 32'h4);
      step();
      count_model(1'b0);
    end
    idle_inputs();
    check_counts("sat_br");
    check("sat_br_all_ones", 32'(br_count), 32'hF);
    for (int k = 0; k < 16; k++) begin
      drive(CMP_EQ, 1'b0, 1'b0, 32'h4, 32'h4, 32'hC00, 32'h4);
      step();
      idle_inputs();
      count_model(1'b1);
      step(); step();
    end
    check_counts("sat_tk");
    check("sat_tk_all_ones", 32'(taken_count), 32'hF);

    // Reset asserted mid-FLUSH clears everything on the next edge
    drive(CMP_EQ, 1'b0, 1'b0, 32'h1, 32'h1, 32'hD00, 32'h6);
    step();
    idle_inputs();
    check("rst_pre_flush", 32'(flush_if_id), 32'h1);
    rst_n = 1'b0;
    step();
    check_all_zero("midrst");
    rst_n = 1'b1;
    br_m = 0; tk_m = 0;
    drive(CMP_LTU, 1'b0, 1'b0, 32'h1, 32'h2, 32'hE00, 32'h8);
    step();
    idle_inputs();
    count_model(1'b1);
    check("postrst_redirect", 32'(redirect_valid), 32'h1);
    check("postrst_pc", redirect_pc, 32'hE08);
    check_counts("postrst");
    step(); step();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage consumer of the 3-bit compare code produced by the branch compare decoder in ID.
- Evaluates conditional branches, JAL and JALR against register operands and computes the target.
- The front end uses a static not-taken policy, so every taken control transfer is a redirect. The block issues a registered one-cycle redirect and then squashes the wrong-path slots with a flush FSM.
- Keeps saturating branch and taken-branch statistics counters.

Parameters:
- XLEN, 32, datapath and PC width.
- FLUSH_CYCLES, 2, number of cycles after a redirect during which EX inputs are wrong-path and ignored. Legal range is 1 to 7.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock; synchronous, active-low
- stall  in  1  EX hold; when high, no evaluation occurs and the FSM and counters are frozen
- valid_ex  in  1  EX slot holds a real instruction
- cmp_ctrl  in  3  compare code from Defines.vh; 0 means not a conditional branch
- is_jal  in  1  EX instruction is JAL
- is_jalr  in  1  EX instruction is JALR
- pc_ex  in  XLEN  PC of the EX instruction
- imm_ex  in  XLEN  sign-extended immediate
- rs1_data  in  XLEN  forwarded rs1 value
- rs2_data  in  XLEN  forwarded rs2 value
- redirect_valid  out  1  one-cycle pulse; fetch must load redirect_pc
- redirect_pc  out  XLEN  target address
- target_misaligned  out  1  one-cycle pulse alongside redirect when target[1] is set
- flush_if_id  out  1  squash the IF/ID register
- flush_id_ex  out  1  squash the ID/EX register
- br_count  out  CNT_W  number of conditional branches evaluated
- taken_count  out  CNT_W  number of conditional branches taken

Behaviour:
- Evaluation happens when valid_ex=1, stall=0 and the FSM is IDLE.
- Compare rules:
  - CMP_EQ / CMP_NE: rs1==rs2 and rs1!=rs2.
  - CMP_LT / CMP_GE: signed, two's complement.
  - CMP_LTU / CMP_GEU: unsigned.
  - Any other nonzero code means not taken, but the branch is still counted.
- Target rules:
  - Conditional branch and JAL: pc_ex+imm_ex, mod 2^XLEN.
  - JALR: (rs1_data+imm_ex) with bit 0 cleared, mod 2^XLEN.
  - target_misaligned = target[1].
- Take decision: JAL and JALR are always taken. A conditional branch is taken per its compare result.
- Priority: is_jalr > is_jal > cmp_ctrl. Multiple asserted is a decoder error, resolved by this priority.
- Latency: the decision is registered. redirect_valid, redirect_pc and target_misaligned appear on the edge after evaluation and are high for exactly one cycle.
- Not-taken result: redirect_valid=0, and redirect_pc holds its previous value.
- FSM states:
  - IDLE: a taken evaluation moves to FLUSH, with flush_cnt loaded to FLUSH_CYCLES.
  - FLUSH: flush_if_id=flush_id_ex=1. flush_cnt decrements on each non-stalled cycle. When flush_cnt reaches 1 and a decrement occurs, return to IDLE.
- Flush output timing: the flush outputs rise in the same cycle as redirect_valid.
- Wrong-path slots in FLUSH: valid_ex is ignored. No evaluation, no counting, no redirect.
- stall=1:
  - No evaluation; the FSM, flush_cnt and counters hold.
  - The flush outputs stay at their state value.
  - A pending redirect_valid pulse still completes and deasserts the next cycle.
- Counters:
  - br_count increments on each evaluated conditional branch (cmp_ctrl!=0).
  - taken_count increments on each such branch that is taken.
  - Both saturate at all-ones. JAL and JALR are not counted.
- Reset (rst_n=0 at an edge, including mid-FLUSH):
  - FSM returns to IDLE with flush_cnt=0.
  - redirect_valid=0, redirect_pc=0, target_misaligned=0.
  - flush_if_id=0, flush_id_ex=0.
  - br_count=0, taken_count=0.
- X-safety: the unit does not evaluate or count when valid_ex=0.

Decomposition:
- The CMP_* codes and CMP_NONE=0 already live in Defines.vh and are used as-is.
- Add BRU_IDLE/BRU_FLUSH state encodings to Defines.vh.
- One natural sub-module, branch_cmp: a purely combinational comparator taking cmp_ctrl, rs1 and rs2 and producing taken. It is reusable for a future ID-stage early resolver.
- The FSM, target adder and counters stay in branch_resolve_unit.

Test Plan:
- CMP_LT, rs1=0xFFFFFFFF, rs2=0x00000001, pc=0x100, imm=0x20 -> next cycle redirect_valid=1, redirect_pc=0x120. Flush is high for 2 cycles and br_count=taken_count=1.
- CMP_LTU with the same operands -> not taken, no redirect, br_count=1, taken_count=0.
- JALR, rs1=0x1003, imm=0x4 -> redirect_pc=0x1006 (bit 0 cleared) and target_misaligned=1. Counters are unchanged.
- Taken BEQ followed by two valid_ex slots, one of which carries a taken BNE -> only the first redirect occurs and br_count=1. After 2 cycles the FSM is back in IDLE.
- Taken branch, then stall=1 for 3 cycles during FLUSH -> redirect pulse lasts 1 cycle and flush stays high for 3+2 cycles total.
- Preload br_count=0xFFFFFFFF, or reset with rst_n=0 asserted mid-FLUSH -> br_count stays saturated. Reset clears all outputs to 0 on the next edge.
